// File: rtl/lpc_buf_arbiter.sv
// lpc_buf_arbiter: shares one single-port byte RAM (the TPM command/response
// buffer) between the lpc_periph data-provider interface and an MCU-side port.
// One access is in flight at a time. The sequence for every access is fixed:
//   IDLE (grant) -> ACC (RAM strobe) -> CAPT (read data capture)
//   -> RESP (done pulse) -> HOLD (wait for the request to drop) -> IDLE
// Handshake: requests are levels held by the requester until it sees its
// 1-cycle done pulse (lpc_wr_done_o / lpc_data_rd_o / mcu_ack_o). The
// arbiter ignores further request activity until that level has dropped.
// All outputs come straight from flops.
module lpc_buf_arbiter #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  UNMAPPED_RD = 8'hFF
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [15:0]       lpc_addr_i,
  input  logic [7:0]        lpc_data_i,
  output logic [7:0]        lpc_data_o,
  input  logic              lpc_data_wr_i,
  output logic              lpc_wr_done_o,
  input  logic              lpc_data_req_i,
  output logic              lpc_data_rd_o,
  input  logic              mcu_req_i,
  input  logic              mcu_we_i,
  input  logic [ADDR_W-1:0] mcu_addr_i,
  input  logic [7:0]        mcu_wdata_i,
  output logic [7:0]        mcu_rdata_o,
  output logic              mcu_ack_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    CAPT = 3'd2,
    RESP = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                last_mcu_q, last_mcu_d;   // rr pointer: 1 = MCU was granted last
  logic                src_lpc_q, src_lpc_d;     // granted side of the access in flight
  logic                we_q, we_d;               // direction of the access in flight
  logic                mapped_q, mapped_d;       // 0 only for out-of-window LPC accesses
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic [7:0]          lpc_data_q, lpc_data_d;
  logic [7:0]          mcu_rdata_q, mcu_rdata_d;
  logic                wr_done_q, wr_done_d;
  logic                data_rd_q, data_rd_d;
  logic                mcu_ack_q, mcu_ack_d;

  logic                lpc_req;
  logic                lpc_mapped;
  logic                grant_lpc;
  logic                grant_we;
  logic                grant_mapped;

  assign lpc_req    = lpc_data_wr_i | lpc_data_req_i;
  assign lpc_mapped = (lpc_addr_i[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d      = state_q;
    last_mcu_d   = last_mcu_q;
    src_lpc_d    = src_lpc_q;
    we_d         = we_q;
    mapped_d     = mapped_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    lpc_data_d   = lpc_data_q;
    mcu_rdata_d  = mcu_rdata_q;
    wr_done_d    = 1'b0;
    data_rd_d    = 1'b0;
    mcu_ack_d    = 1'b0;
    grant_lpc    = 1'b0;
    grant_we     = 1'b0;
    grant_mapped = 1'b0;

    case (state_q)
      IDLE: begin
        if (lpc_req || mcu_req_i) begin
          // A lone requester wins; on a tie the side not granted last wins.
          grant_lpc = lpc_req && (!mcu_req_i || last_mcu_q);
          if (grant_lpc) begin
            // Write takes priority when both LPC strobes are high.
            grant_we     = lpc_data_wr_i;
            grant_mapped = lpc_mapped;
            ram_addr_d   = lpc_addr_i[ADDR_W-1:0];
            ram_wdata_d  = lpc_data_i;
          end else begin
            grant_we     = mcu_we_i;
            grant_mapped = 1'b1;
            ram_addr_d   = mcu_addr_i;
            ram_wdata_d  = mcu_wdata_i;
          end
          src_lpc_d  = grant_lpc;
          last_mcu_d = !grant_lpc;
          we_d       = grant_we;
          mapped_d   = grant_mapped;
          ram_en_d   = grant_mapped;
          ram_we_d   = grant_mapped && grant_we;
          state_d    = ACC;
        end
      end
      ACC: begin
        state_d = CAPT;
      end
      CAPT: begin
        // RAM read data is valid now, one cycle after the strobe.
        if (!we_q) begin
          if (src_lpc_q) begin
            lpc_data_d = mapped_q ? ram_rdata_i : UNMAPPED_RD;
          end else begin
            mcu_rdata_d = ram_rdata_i;
          end
        end
        if (src_lpc_q) begin
          wr_done_d = we_q;
          data_rd_d = !we_q;
        end else begin
          mcu_ack_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (src_lpc_q ? !lpc_req : !mcu_req_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= IDLE;
      last_mcu_q  <= 1'b1;
      src_lpc_q   <= 1'b0;
      we_q        <= 1'b0;
      mapped_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      lpc_data_q  <= '0;
      mcu_rdata_q <= '0;
      wr_done_q   <= 1'b0;
      data_rd_q   <= 1'b0;
      mcu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mcu_q  <= last_mcu_d;
      src_lpc_q   <= src_lpc_d;
      we_q        <= we_d;
      mapped_q    <= mapped_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      lpc_data_q  <= lpc_data_d;
      mcu_rdata_q <= mcu_rdata_d;
      wr_done_q   <= wr_done_d;
      data_rd_q   <= data_rd_d;
      mcu_ack_q   <= mcu_ack_d;
    end
  end

  assign lpc_data_o    = lpc_data_q;
  assign lpc_wr_done_o = wr_done_q;
  assign lpc_data_rd_o = data_rd_q;
  assign mcu_rdata_o   = mcu_rdata_q;
  assign mcu_ack_o     = mcu_ack_q;
  assign ram_en_o      = ram_en_q;
  assign ram_we_o      = ram_we_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_wdata_o   = ram_wdata_q;

endmodule

// File: tb/tb_lpc_buf_arbiter.sv
// Directed bench for lpc_buf_arbiter. Inputs change and outputs are checked
// on the falling edge; the DUT acts on the rising edge.
module tb_lpc_buf_arbiter;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              nrst;
  logic [15:0]       lpc_addr;
  logic [7:0]        lpc_wdata;
  logic [7:0]        lpc_data_o;
  logic              lpc_wr;
  logic              lpc_wr_done;
  logic              lpc_rd_req;
  logic              lpc_data_rd;
  logic              mcu_req;
  logic              mcu_we;
  logic [ADDR_W-1:0] mcu_addr;
  logic [7:0]        mcu_wdata;
  logic [7:0]        mcu_rdata;
  logic              mcu_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata = 8'h00;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int overlap_cnt = 0;
  logic prev_en = 1'b0;

  logic [7:0] mem [0:4095];

  // clock / reset block
  always #5 clk = ~clk;

  lpc_buf_arbiter #(
    .BASE_ADDR   (16'h0000),
    .ADDR_W      (ADDR_W),
    .UNMAPPED_RD (8'hFF)
  ) dut (
    .clk_i          (clk),
    .nrst_i         (nrst),
    .lpc_addr_i     (lpc_addr),
    .lpc_data_i     (lpc_wdata),
    .lpc_data_o     (lpc_data_o),
    .lpc_data_wr_i  (lpc_wr),
    .lpc_wr_done_o  (lpc_wr_done),
    .lpc_data_req_i (lpc_rd_req),
    .lpc_data_rd_o  (lpc_data_rd),
    .mcu_req_i      (mcu_req),
    .mcu_we_i       (mcu_we),
    .mcu_addr_i     (mcu_addr),
    .mcu_wdata_i    (mcu_wdata),
    .mcu_rdata_o    (mcu_rdata),
    .mcu_ack_o      (mcu_ack),
    .ram_en_o       (ram_en),
    .ram_we_o       (ram_we),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata)
  );

  // single-port RAM with one cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // strobe monitor: count accesses and back-to-back strobes
  always @(negedge clk) begin
    if (ram_en) en_cnt <= en_cnt + 1;
    if (ram_en && prev_en) overlap_cnt <= overlap_cnt + 1;
    prev_en <= ram_en;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lpc_data"}, {8'h0, lpc_data_o}, 16'h0);
    check({tag, "_wr_done"}, {15'h0, lpc_wr_done}, 16'h0);
    check({tag, "_data_rd"}, {15'h0, lpc_data_rd}, 16'h0);
    check({tag, "_mcu_rdata"}, {8'h0, mcu_rdata}, 16'h0);
    check({tag, "_mcu_ack"}, {15'h0, mcu_ack}, 16'h0);
    check({tag, "_ram_en"}, {15'h0, ram_en}, 16'h0);
    check({tag, "_ram_we"}, {15'h0, ram_we}, 16'h0);
    check({tag, "_ram_addr"}, {4'h0, ram_addr}, 16'h0);
    check({tag, "_ram_wdata"}, {8'h0, ram_wdata}, 16'h0);
  endtask

  initial begin
    nrst = 1'b0;
    lpc_addr = '0; lpc_wdata = '0; lpc_wr = 1'b0; lpc_rd_req = 1'b0;
    mcu_req = 1'b0; mcu_we = 1'b0; mcu_addr = '0; mcu_wdata = '0;
    step(); step();
    check_all_zero("reset");
    nrst = 1'b1;

    // MCU write 0x010 <= 3C
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 12'h010; mcu_wdata = 8'h3C;
    step();
    check("t0_en", {15'h0, ram_en}, 16'h1);
    check("t0_we", {15'h0, ram_we}, 16'h1);
    check("t0_addr", {4'h0, ram_addr}, 16'h010);
    check("t0_wdata", {8'h0, ram_wdata}, 16'h3C);
    step();
    check("t0_ack_early", {15'h0, mcu_ack}, 16'h0);
    step();
    check("t0_ack", {15'h0, mcu_ack}, 16'h1);
    mcu_req = 1'b0; mcu_we = 1'b0;
    step();
    check("t0_ack_drop", {15'h0, mcu_ack}, 16'h0);
    step();

    // LPC write 0x0F00 <= A5
    lpc_addr = 16'h0F00; lpc_wdata = 8'hA5; lpc_wr = 1'b1;
    step();
    check("t1_en", {15'h0, ram_en}, 16'h1);
    check("t1_we", {15'h0, ram_we}, 16'h1);
    check("t1_addr", {4'h0, ram_addr}, 16'hF00);
    check("t1_wdata", {8'h0, ram_wdata}, 16'hA5);
    step();
    check("t1_en_once", {15'h0, ram_en}, 16'h0);
    check("t1_done_early", {15'h0, lpc_wr_done}, 16'h0);
    step();
    check("t1_done", {15'h0, lpc_wr_done}, 16'h1);
    check("t1_no_rd", {15'h0, lpc_data_rd}, 16'h0);
    lpc_wr = 1'b0;
    step();
    check("t1_done_pulse", {15'h0, lpc_wr_done}, 16'h0);
    step();

    // LPC read 0x0010 -> 3C
    lpc_addr = 16'h0010; lpc_rd_req = 1'b1;
    step();
    check("t2_en", {15'h0, ram_en}, 16'h1);
    check("t2_we", {15'h0, ram_we}, 16'h0);
    check("t2_addr", {4'h0, ram_addr}, 16'h010);
    step();
    step();
    check("t2_rd", {15'h0, lpc_data_rd}, 16'h1);
    check("t2_data", {8'h0, lpc_data_o}, 16'h3C);
    lpc_rd_req = 1'b0;
    step();
    check("t2_rd_pulse", {15'h0, lpc_data_rd}, 16'h0);
    check("t2_data_held", {8'h0, lpc_data_o}, 16'h3C);
    step();

    // unmapped read and write
    lpc_addr = 16'h1234; lpc_rd_req = 1'b1;
    step();
    check("t3r_no_en", {15'h0, ram_en}, 16'h0);
    step();
    step();
    check("t3r_rd", {15'h0, lpc_data_rd}, 16'h1);
    check("t3r_data", {8'h0, lpc_data_o}, 16'hFF);
    lpc_rd_req = 1'b0;
    step();
    step();
    lpc_addr = 16'h2000; lpc_wdata = 8'h77; lpc_wr = 1'b1;
    step();
    check("t3w_no_en", {15'h0, ram_en}, 16'h0);
    step();
    step();
    check("t3w_done", {15'h0, lpc_wr_done}, 16'h1);
    lpc_wr = 1'b0;
    step();
    step();
    check("t3_en_count", 16'(en_cnt), 16'd3);

    // reset, then simultaneous LPC read and MCU write: LPC first
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    lpc_addr = 16'h0010; lpc_rd_req = 1'b1;
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 12'h005; mcu_wdata = 8'h5A;
    step();
    check("t4a_en", {15'h0, ram_en}, 16'h1);
    check("t4a_we", {15'h0, ram_we}, 16'h0);
    check("t4a_addr", {4'h0, ram_addr}, 16'h010);
    step();
    step();
    check("t4a_rd", {15'h0, lpc_data_rd}, 16'h1);
    check("t4a_data", {8'h0, lpc_data_o}, 16'h3C);
    check("t4a_no_ack", {15'h0, mcu_ack}, 16'h0);
    lpc_rd_req = 1'b0;
    step();
    check("t4a_hold_no_en", {15'h0, ram_en}, 16'h0);
    step();
    check("t4a_idle_no_en", {15'h0, ram_en}, 16'h0);
    step();
    check("t4b_en", {15'h0, ram_en}, 16'h1);
    check("t4b_we", {15'h0, ram_we}, 16'h1);
    check("t4b_addr", {4'h0, ram_addr}, 16'h005);
    check("t4b_wdata", {8'h0, ram_wdata}, 16'h5A);
    step();
    step();
    check("t4b_ack", {15'h0, mcu_ack}, 16'h1);
    mcu_req = 1'b0; mcu_we = 1'b0;
    step();
    step();

    // lone LPC write, so the next tie goes to the MCU
    lpc_addr = 16'h0020; lpc_wdata = 8'h11; lpc_wr = 1'b1;
    step();
    step();
    step();
    check("t4c_done", {15'h0, lpc_wr_done}, 16'h1);
    lpc_wr = 1'b0;
    step();
    step();

    // tie: LPC read 0x005 and MCU read 0xF00 -> MCU first
    lpc_addr = 16'h0005; lpc_rd_req = 1'b1;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 12'hF00;
    step();
    check("t4d_en", {15'h0, ram_en}, 16'h1);
    check("t4d_addr", {4'h0, ram_addr}, 16'hF00);
    step();
    step();
    check("t4d_ack", {15'h0, mcu_ack}, 16'h1);
    check("t4d_rdata", {8'h0, mcu_rdata}, 16'hA5);
    check("t4d_no_rd", {15'h0, lpc_data_rd}, 16'h0);
    mcu_req = 1'b0;
    step();
    step();
    step();
    check("t4e_en", {15'h0, ram_en}, 16'h1);
    check("t4e_addr", {4'h0, ram_addr}, 16'h005);
    step();
    step();
    check("t4e_rd", {15'h0, lpc_data_rd}, 16'h1);
    check("t4e_data", {8'h0, lpc_data_o}, 16'h5A);
    lpc_rd_req = 1'b0;
    step();
    step();

    // read request held long after the data pulse
    lpc_addr = 16'h0010; lpc_rd_req = 1'b1;
    step();
    check("t5_en", {15'h0, ram_en}, 16'h1);
    step();
    step();
    check("t5_rd", {15'h0, lpc_data_rd}, 16'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_held_no_rd", {15'h0, lpc_data_rd}, 16'h0);
      check("t5_held_no_en", {15'h0, ram_en}, 16'h0);
    end
    lpc_rd_req = 1'b0;
    step();
    step();
    check("t5_en_count", 16'(en_cnt), 16'd9);

    // reset during ACC of an MCU read
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 12'h005;
    step();
    check("t6_en", {15'h0, ram_en}, 16'h1);
    #1 nrst = 1'b0;
    #1 check_all_zero("t6_async");
    step();
    check("t6_no_ack_1", {15'h0, mcu_ack}, 16'h0);
    step();
    check("t6_no_ack_2", {15'h0, mcu_ack}, 16'h0);
    check("t6_no_en", {15'h0, ram_en}, 16'h0);
    nrst = 1'b1;
    step();
    check("t6r_en", {15'h0, ram_en}, 16'h1);
    check("t6r_addr", {4'h0, ram_addr}, 16'h005);
    step();
    check("t6r_no_ack", {15'h0, mcu_ack}, 16'h0);
    step();
    check("t6r_ack", {15'h0, mcu_ack}, 16'h1);
    check("t6r_rdata", {8'h0, mcu_rdata}, 16'h5A);
    mcu_req = 1'b0;
    step();
    check("t6r_ack_pulse", {15'h0, mcu_ack}, 16'h0);
    step();
    #1;
    check("final_en_count", 16'(en_cnt), 16'd11);
    check("final_overlap", 16'(overlap_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
